// File: rtl/fifo_traffic_sched_if.sv
// Scheduler <-> bench/FIFO handshake bundle: run control, FIFO enables/flags and run statistics.
// The master side is the scheduler; the slave side is whatever drives start and the FIFO flags.
interface fifo_traffic_sched_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             we;
    logic             wrdy;
    logic             re;
    logic             rrdy;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] wr_stall_cnt;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] peak_occ;

    modport master (
        input  start, wrdy, rrdy,
        output we, re, busy, done, wr_stall_cnt, occ, peak_occ
    );

    modport slave (
        output start, wrdy, rrdy,
        input  we, re, busy, done, wr_stall_cnt, occ, peak_occ
    );
endinterface

// File: rtl/fifo_traffic_sched.sv
// Burst traffic scheduler: independent write and read FSMs drive a FIFO's enables in
// parameterised bursts and gaps, and track stalls, occupancy and peak occupancy per run.
module fifo_traffic_sched #(
    parameter int WRITE_BURST_SIZE                 = 10,
    parameter int WRITE_IDLE_CYCLES_BETWEEN_BURSTS = 10,
    parameter int WRITE_NUMBER_OF_BURSTS           = 10,
    parameter int READ_BURST_SIZE                  = 10,
    parameter int READ_IDLE_CYCLES_BETWEEN_BURSTS  = 10,
    parameter int CNT_W                            = 16
) (
    input  logic                clk,
    input  logic                rst,
    fifo_traffic_sched_if.master bus
);
    localparam int TOTAL = WRITE_BURST_SIZE * WRITE_NUMBER_OF_BURSTS;
    localparam int WI    = WRITE_IDLE_CYCLES_BETWEEN_BURSTS;
    localparam int RI    = READ_IDLE_CYCLES_BETWEEN_BURSTS;

    // Gap counters get one spare code so a zero idle count still yields a legal width.
    localparam int WB_W = $clog2(WRITE_BURST_SIZE + 1);
    localparam int WN_W = $clog2(WRITE_NUMBER_OF_BURSTS + 1);
    localparam int WG_W = $clog2(WI + 2);
    localparam int RB_W = $clog2(READ_BURST_SIZE + 1);
    localparam int RG_W = $clog2(RI + 2);
    localparam int RT_W = $clog2(TOTAL + 1);

    localparam logic [WB_W-1:0]  WB_LAST = WB_W'(WRITE_BURST_SIZE - 1);
    localparam logic [WN_W-1:0]  WN_LAST = WN_W'(WRITE_NUMBER_OF_BURSTS - 1);
    localparam logic [WG_W-1:0]  WG_LAST = WG_W'((WI > 0) ? WI - 1 : 0);
    localparam logic [RB_W-1:0]  RB_LAST = RB_W'(READ_BURST_SIZE - 1);
    localparam logic [RG_W-1:0]  RG_LAST = RG_W'((RI > 0) ? RI - 1 : 0);
    localparam logic [RT_W-1:0]  RT_LAST = RT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {W_IDLE, W_BURST, W_GAP, W_DONE} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_BURST, R_GAP, R_DONE} rstate_t;

    wstate_t          wstate, wstate_nx;
    rstate_t          rstate, rstate_nx;
    logic [WB_W-1:0]  wb_cnt;
    logic [WN_W-1:0]  wn_cnt;
    logic [WG_W-1:0]  wg_cnt;
    logic [RB_W-1:0]  rb_cnt;
    logic [RG_W-1:0]  rg_cnt;
    logic [RT_W-1:0]  rt_cnt;
    logic [CNT_W-1:0] stall_cnt, occ, occ_nx, peak;
    logic             we, re, busy, done;
    logic             go, w_acc, w_burst_end, r_burst_end, r_fin;

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_nx;
            rstate <= rstate_nx;
        end
    end

    // ---------------- outputs decoded from state ----------------
    always_comb begin
        we   = (wstate == W_BURST);
        re   = (rstate == R_BURST) && bus.rrdy;
        busy = !((wstate == W_IDLE || wstate == W_DONE) &&
                 (rstate == R_IDLE || rstate == R_DONE));
        done = (wstate == W_DONE) && (rstate == R_DONE);
    end

    assign go          = bus.start && !busy;
    assign w_acc       = we && bus.wrdy;
    assign w_burst_end = w_acc && (wb_cnt == WB_LAST);
    assign r_burst_end = re && (rb_cnt == RB_LAST);
    assign r_fin       = re && (rt_cnt == RT_LAST);

    // ---------------- write next state ----------------
    always_comb begin
        wstate_nx = wstate;
        case (wstate)
            W_IDLE, W_DONE: if (go) wstate_nx = W_BURST;
            W_BURST: begin
                if (w_burst_end) begin
                    if (wn_cnt == WN_LAST) wstate_nx = W_DONE;
                    else if (WI != 0)      wstate_nx = W_GAP;
                end
            end
            W_GAP:   if (wg_cnt == WG_LAST) wstate_nx = W_BURST;
            default: wstate_nx = W_IDLE;
        endcase
    end

    // ---------------- read next state ----------------
    // Finishing the run wins over a burst boundary, which truncates the last burst.
    always_comb begin
        rstate_nx = rstate;
        case (rstate)
            R_IDLE, R_DONE: if (go) rstate_nx = R_BURST;
            R_BURST: begin
                if (r_fin)            rstate_nx = R_DONE;
                else if (r_burst_end && RI != 0) rstate_nx = R_GAP;
            end
            R_GAP:   if (rg_cnt == RG_LAST) rstate_nx = R_BURST;
            default: rstate_nx = R_IDLE;
        endcase
    end

    // ---------------- burst / gap counters ----------------
    always_ff @(posedge clk) begin
        if (rst || go) begin
            wb_cnt <= '0;
            wn_cnt <= '0;
            wg_cnt <= '0;
        end else begin
            if (w_acc) wb_cnt <= w_burst_end ? '0 : wb_cnt + 1'b1;
            if (w_burst_end && wn_cnt != WN_LAST) wn_cnt <= wn_cnt + 1'b1;
            if (wstate == W_GAP) wg_cnt <= (wg_cnt == WG_LAST) ? '0 : wg_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || go) begin
            rb_cnt <= '0;
            rg_cnt <= '0;
            rt_cnt <= '0;
        end else begin
            if (re) rb_cnt <= r_burst_end ? '0 : rb_cnt + 1'b1;
            if (re && !r_fin) rt_cnt <= rt_cnt + 1'b1;
            if (rstate == R_GAP) rg_cnt <= (rg_cnt == RG_LAST) ? '0 : rg_cnt + 1'b1;
        end
    end

    // ---------------- run statistics ----------------
    always_comb begin
        occ_nx = occ;
        if (w_acc && !re)      occ_nx = occ + 1'b1;
        else if (!w_acc && re) occ_nx = occ - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || go) begin
            stall_cnt <= '0;
            occ       <= '0;
            peak      <= '0;
        end else begin
            if (we && !bus.wrdy && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            occ <= occ_nx;
            if (occ_nx > peak) peak <= occ_nx;
        end
    end

    assign bus.we           = we;
    assign bus.re           = re;
    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.wr_stall_cnt = stall_cnt;
    assign bus.occ          = occ;
    assign bus.peak_occ     = peak;
endmodule

// File: tb/tb_fifo_traffic_sched.sv
// Bench: four scheduler configurations against ideal FIFOs, a per-cycle burst-arithmetic
// reference model, a table of whole-run vectors and a few hand-written corner sequences.
module tb_fifo_traffic_sched;
    localparam int CW = 16;
    localparam int NI = 4;
    // Per-instance configuration, index 0 in the low byte.
    localparam logic [NI-1:0][7:0] P_WBS = {8'd4, 8'd4, 8'd4, 8'd4};
    localparam logic [NI-1:0][7:0] P_WI  = {8'd2, 8'd0, 8'd2, 8'd2};
    localparam logic [NI-1:0][7:0] P_WNB = {8'd3, 8'd3, 8'd3, 8'd3};
    localparam logic [NI-1:0][7:0] P_RBS = {8'd4, 8'd5, 8'd1, 8'd4};
    localparam logic [NI-1:0][7:0] P_RI  = {8'd0, 8'd0, 8'd3, 8'd0};
    localparam logic [NI-1:0][7:0] P_DEP = {8'd16, 8'd16, 8'd2, 8'd16};
    localparam logic [NI-1:0][7:0] P_CW  = {8'd3, 8'd16, 8'd16, 8'd16};

    logic clk = 1'b0;
    logic rst;
    logic chk_en;
    logic [NI-1:0] start_v, hold;
    logic [NI-1:0] we_w, re_w, wrdy_w, rrdy_w, busy_w, done_w;
    logic [CW-1:0] stall_w [NI];
    logic [CW-1:0] occ_w   [NI];
    logic [CW-1:0] peak_w  [NI];
    int fcnt [NI];
    int acc_tot [NI];
    int rd_tot [NI];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fifo_traffic_sched_if #(.CNT_W(int'(P_CW[g]))) bus ();
        fifo_traffic_sched #(
            .WRITE_BURST_SIZE                (int'(P_WBS[g])),
            .WRITE_IDLE_CYCLES_BETWEEN_BURSTS(int'(P_WI[g])),
            .WRITE_NUMBER_OF_BURSTS          (int'(P_WNB[g])),
            .READ_BURST_SIZE                 (int'(P_RBS[g])),
            .READ_IDLE_CYCLES_BETWEEN_BURSTS (int'(P_RI[g])),
            .CNT_W                           (int'(P_CW[g]))
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.start  = start_v[g];
        assign bus.wrdy   = wrdy_w[g];
        assign bus.rrdy   = rrdy_w[g];
        assign we_w[g]    = bus.we;
        assign re_w[g]    = bus.re;
        assign busy_w[g]  = bus.busy;
        assign done_w[g]  = bus.done;
        assign stall_w[g] = CW'(bus.wr_stall_cnt);
        assign occ_w[g]   = CW'(bus.occ);
        assign peak_w[g]  = CW'(bus.peak_occ);
        // Ideal FIFO flags; hold forces a full indication to create write stalls.
        assign wrdy_w[g]  = (fcnt[g] < int'(P_DEP[g])) && !hold[g];
        assign rrdy_w[g]  = (fcnt[g] > 0);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                fcnt[i]    <= 0;
                acc_tot[i] <= 0;
                rd_tot[i]  <= 0;
            end else begin
                fcnt[i] <= fcnt[i] + int'(we_w[i] && wrdy_w[i]) - int'(re_w[i]);
                if (we_w[i] && wrdy_w[i]) acc_tot[i] <= acc_tot[i] + 1;
                if (re_w[i]) rd_tot[i] <= rd_tot[i] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst %0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // State is expressed as run totals and remaining gap cycles, not FSM states.
    bit m_act   [NI];
    int m_acc   [NI];
    int m_rd    [NI];
    int m_wgap  [NI];
    int m_rgap  [NI];
    longint m_stall [NI];
    int m_occ   [NI];
    int m_peak  [NI];

    task automatic model_cycle(input int i);
        int tot, wbs, rbs;
        longint sat;
        bit e_we, e_re, e_done, e_busy, acc, rd;
        tot = int'(P_WBS[i]) * int'(P_WNB[i]);
        wbs = int'(P_WBS[i]);
        rbs = int'(P_RBS[i]);
        sat = (longint'(1) << P_CW[i]) - 1;
        e_we   = m_act[i] && (m_acc[i] < tot) && (m_wgap[i] == 0);
        e_re   = m_act[i] && (m_rd[i] < tot) && (m_rgap[i] == 0) && rrdy_w[i];
        e_done = m_act[i] && (m_acc[i] == tot) && (m_rd[i] == tot);
        e_busy = m_act[i] && !e_done;
        chk("m_we",    i, we_w[i],    e_we);
        chk("m_re",    i, re_w[i],    e_re);
        chk("m_busy",  i, busy_w[i],  e_busy);
        chk("m_done",  i, done_w[i],  e_done);
        chk("m_stall", i, stall_w[i], m_stall[i]);
        chk("m_occ",   i, occ_w[i],   m_occ[i]);
        chk("m_peak",  i, peak_w[i],  m_peak[i]);
        if (rst || (start_v[i] && !e_busy)) begin
            m_act[i] = !rst;
            m_acc[i] = 0; m_rd[i] = 0; m_wgap[i] = 0; m_rgap[i] = 0;
            m_stall[i] = 0; m_occ[i] = 0; m_peak[i] = 0;
        end else begin
            acc = e_we && wrdy_w[i];
            rd  = e_re;
            if (e_we && !wrdy_w[i] && m_stall[i] < sat) m_stall[i]++;
            if (m_wgap[i] > 0) m_wgap[i]--;
            if (m_rgap[i] > 0) m_rgap[i]--;
            if (acc) begin
                m_acc[i]++;
                if (m_acc[i] % wbs == 0 && m_acc[i] < tot) m_wgap[i] = int'(P_WI[i]);
            end
            if (rd) begin
                m_rd[i]++;
                if (m_rd[i] % rbs == 0 && m_rd[i] < tot) m_rgap[i] = int'(P_RI[i]);
            end
            m_occ[i] = m_occ[i] + int'(acc) - int'(rd);
            if (m_occ[i] > m_peak[i]) m_peak[i] = m_occ[i];
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) for (int i = 0; i < NI; i++) model_cycle(i);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int inst;
        int stall_len;
        int exp_xfer;
        int exp_stall;
        bit stall_any;
        int exp_peak;
    } vec_t;

    localparam int NV = 5;
    vec_t vt [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, input int budget);
        for (int c = 0; c < budget && !done_w[k]; c++) tick();
        chk("done", k, done_w[k], 1);
    endtask

    task automatic chk_zero(input string nm, input int k);
        chk({nm, "_we"},    k, we_w[k],    0);
        chk({nm, "_re"},    k, re_w[k],    0);
        chk({nm, "_busy"},  k, busy_w[k],  0);
        chk({nm, "_done"},  k, done_w[k],  0);
        chk({nm, "_stall"}, k, stall_w[k], 0);
        chk({nm, "_occ"},   k, occ_w[k],   0);
        chk({nm, "_peak"},  k, peak_w[k],  0);
    endtask

    initial begin
        int k, a0, r0;
        bit inj;
        logic [15:0] p1, p2;
        logic [12:0] p3;

        vt[0] = '{inst: 0, stall_len: 0,  exp_xfer: 12, exp_stall: 0, stall_any: 1'b0, exp_peak: 1};
        vt[1] = '{inst: 0, stall_len: 5,  exp_xfer: 12, exp_stall: 5, stall_any: 1'b0, exp_peak: 1};
        vt[2] = '{inst: 1, stall_len: 0,  exp_xfer: 12, exp_stall: 0, stall_any: 1'b1, exp_peak: 2};
        vt[3] = '{inst: 2, stall_len: 0,  exp_xfer: 12, exp_stall: 0, stall_any: 1'b0, exp_peak: 1};
        vt[4] = '{inst: 3, stall_len: 10, exp_xfer: 12, exp_stall: 7, stall_any: 1'b0, exp_peak: 1};

        rst = 1'b1; start_v = '0; hold = '0; chk_en = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        for (int i = 0; i < NI; i++) chk_zero("reset", i);
        rst = 1'b0;
        tick();

        // Whole-run vectors.
        for (int v = 0; v < NV; v++) begin
            k = vt[v].inst; a0 = acc_tot[k]; r0 = rd_tot[k]; inj = 1'b0;
            start_v[k] = 1'b1; tick(); start_v[k] = 1'b0;
            for (int c = 0; c < 400 && !done_w[k]; c++) begin
                if (vt[v].stall_len > 0 && !inj && acc_tot[k] - a0 == 5) begin
                    hold[k] = 1'b1;
                    repeat (vt[v].stall_len) tick();
                    hold[k] = 1'b0;
                    inj = 1'b1;
                end else begin
                    tick();
                end
            end
            chk("vec_done",   k, done_w[k], 1);
            chk("vec_busy",   k, busy_w[k], 0);
            chk("vec_writes", k, acc_tot[k] - a0, vt[v].exp_xfer);
            chk("vec_reads",  k, rd_tot[k] - r0, vt[v].exp_xfer);
            if (vt[v].stall_any) chk("vec_stall_nonzero", k, stall_w[k] != 0, 1);
            else                 chk("vec_stall", k, stall_w[k], vt[v].exp_stall);
            chk("vec_peak", k, peak_w[k], vt[v].exp_peak);
            chk("vec_occ",  k, occ_w[k], 0);
            tick();
        end

        // Base write pattern, with a start pulse mid-run that must be ignored.
        a0 = acc_tot[0]; r0 = rd_tot[0];
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        for (int c = 0; c < 16; c++) begin
            p1[15-c] = we_w[0];
            start_v[0] = (c == 3);
            tick();
        end
        start_v[0] = 1'b0;
        chk("we_pattern", 0, p1, 16'b1111001111001111);
        wait_done(0, 100);
        chk("run1_reads", 0, rd_tot[0] - a0 + a0 - r0, 12);

        // Restart from DONE clears done and counters, then repeats the same pattern.
        r0 = rd_tot[0];
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        chk("restart_done", 0, done_w[0], 0);
        chk("restart_busy", 0, busy_w[0], 1);
        chk("restart_peak", 0, peak_w[0], 0);
        chk("restart_occ",  0, occ_w[0],  0);
        for (int c = 0; c < 16; c++) begin
            p2[15-c] = we_w[0];
            tick();
        end
        chk("we_pattern_rerun", 0, p2, p1);
        wait_done(0, 100);
        chk("run2_reads", 0, rd_tot[0] - r0, 12);

        // Zero write gap: twelve back-to-back write enables.
        r0 = rd_tot[2];
        start_v[2] = 1'b1; tick(); start_v[2] = 1'b0;
        for (int c = 0; c < 13; c++) begin
            p3[12-c] = we_w[2];
            tick();
        end
        chk("we_nogap", 2, p3, 13'b1111111111110);
        wait_done(2, 100);
        chk("nogap_reads", 2, rd_tot[2] - r0, 12);

        // Reset in the middle of burst 2, then a clean run.
        a0 = acc_tot[0];
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        for (int c = 0; c < 60 && acc_tot[0] - a0 < 6; c++) tick();
        chk("mid_burst2", 0, acc_tot[0] - a0, 6);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_zero("abort", 0);
        r0 = rd_tot[0];
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        wait_done(0, 100);
        chk("post_reset_reads", 0, rd_tot[0] - r0, 12);
        chk("post_reset_stall", 0, stall_w[0], 0);

        // Randomised traffic; the reference model checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NI; i++) begin
                hold[i]    = ($urandom_range(0, 3) == 0);
                start_v[i] = ($urandom_range(0, 19) == 0);
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; start_v = '0; hold = '0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
